keypad_matrix_capture: RTL and testbench
========================================

# keypad_matrix_capture

Parametrised matrix-keypad front end: scans an R×C key matrix one column at a time, synchronises and debounces the row returns, and emits exactly one key event per physical press. Each accepted key is also pushed into a HIST_DEPTH-deep history register. Sits between the keypad pins and the display/digit logic, replacing the separate scan/decode/store path with one configurable block.

## Interface
- ROWS, 4, number of row inputs
- COLS, 4, number of column outputs
- SETTLE_CYCLES, 4, clocks each column is driven before rows are sampled; must be ≥3 to cover synchroniser latency
- DEBOUNCE_CYCLES, 8, consecutive stable clocks required for press and for release; must be ≥1
- HIST_DEPTH, 2, number of stored key codes; must be ≥1
- ACTIVE_LOW, 1, 1 = active column driven 0 and a pressed row reads 0; 0 = both active-high
- KEY_W (localparam) = $clog2(ROWS*COLS)
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- row_in  in  ROWS  raw asynchronous row pins
- col  out  COLS  column drive; exactly one column active at all times
- key_code  out  KEY_W  code of the last accepted key = row_idx*COLS + col_idx
- key_valid  out  1  one-cycle strobe when key_code updates
- hist  out  HIST_DEPTH*KEY_W  history; slice 0 (LSBs) is newest
- multi_err  out  1  one-cycle strobe when a sample shows more than one row active

## Operation
- Rows pass through a two-flop synchroniser and are normalised to active-high internally (inverted when ACTIVE_LOW=1).
- FSM states: SCAN, DEBOUNCE, HELD, RELEASE.
- **SCAN:** drive col_idx for SETTLE_CYCLES clocks, then sample rows on the last dwell cycle.
  - Zero rows active: advance col_idx, wrapping COLS-1→0.
  - Exactly one row active: latch row_idx, go to DEBOUNCE.
  - Two or more rows active: pulse multi_err, treat as no press, advance col_idx.
- **DEBOUNCE:** column held. Counter runs while the latched row bit stays set.
  - Bit drops: return to SCAN and advance col_idx. No event.
  - Count reaches DEBOUNCE_CYCLES: update key_code, pulse key_valid, shift hist (newest into slice 0, oldest discarded), go to HELD.
- **HELD:** column held, no events.
  - Other rows in the same column are ignored.
  - Keys in other columns are invisible because their columns are not driven.
  - Latched row bit clears: go to RELEASE.
- **RELEASE:** counts consecutive cycles with the latched bit clear.
  - Bit reappears: return to HELD and clear the counter.
  - Count reaches DEBOUNCE_CYCLES: advance col_idx, go to SCAN.
- One press produces exactly one key_valid, with no auto-repeat regardless of hold time.
- Counter width is $clog2(max(SETTLE_CYCLES, DEBOUNCE_CYCLES)+1). Counters never wrap: each is cleared on every state entry.

## Timing
- All outputs are registered.
- Reset values:
  - col = column 0 active (ACTIVE_LOW=1: 'b…1110).
  - key_code = 0, key_valid = 0, hist = 0, multi_err = 0.
  - State SCAN, counters 0.
- Reset asserted mid-operation (any state) aborts immediately. No key_valid on reset or on release; scanning restarts at column 0.
- Pin to internal row: 2 cycles.
- key_valid rises on the clock edge DEBOUNCE_CYCLES cycles after DEBOUNCE is entered. key_code and hist change on that same edge.
- Worst-case press-detect latency = COLS*SETTLE_CYCLES + 2 + DEBOUNCE_CYCLES cycles.
- col changes only on a SCAN dwell-end edge or a RELEASE-complete edge.
- multi_err and key_valid are never high in the same cycle.

## Structure
- Shared package `keypad_pkg`:
  - typedef enum for the FSM states (SCAN, DEBOUNCE, HELD, RELEASE).
  - Function computing the key code from row_idx/col_idx.
- Sub-module: the existing two-flop `synchronizer`, instantiated with WIDTH=ROWS.
- Everything else lives in one module: FSM, counters, history shift register.

## Test plan
All scenarios use ROWS=4, COLS=4, SETTLE=4, DEBOUNCE=8, HIST_DEPTH=3, ACTIVE_LOW=1.
1. Reset → col=4'b1110, key_code=0, hist=0; col steps 1110→1101→1011→0111→1110 every 4 cycles with no press.
2. Press row 2/col 1 clean for 50 cycles, then release → exactly one key_valid, key_code=9, hist slice0=9.
3. Bounce: row 2/col 1 active 5 cycles, off 1, then stable → no event from the first burst; one key_valid with code 9 after the stable run.
4. Rows 0 and 3 both active on col 2 → multi_err pulses once per col-2 visit; no key_valid; scan continues.
5. Keys 1, 5, 10, 15 in sequence (each released) → final hist = {5,10,15} (slice2..slice0), key_code=15.
6. Reset asserted mid-DEBOUNCE and mid-HELD → no key_valid, col returns to 1110 at once, hist cleared.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared types and helpers for the matrix keypad front end.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2,
    RELEASE  = 2'd3
  } kp_state_e;

  function automatic int unsigned key_code_f(input int unsigned row_idx,
                                             input int unsigned col_idx,
                                             input int unsigned cols);
    return row_idx * cols + col_idx;
  endfunction

  function automatic int unsigned max_f(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/synchronizer.sv
// Two-flop synchroniser for asynchronous level inputs; resets to RESET_VAL so
// idle pins do not look active while the chain fills.
module synchronizer #(
  parameter int   WIDTH     = 1,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= {WIDTH{RESET_VAL}};
      sync_q <= {WIDTH{RESET_VAL}};
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/keypad_matrix_capture.sv
// Column-scanning keypad front end: one key event per debounced press, plus a
// short shift-register history of accepted key codes (slice 0 newest).
module keypad_matrix_capture
  import keypad_pkg::*;
#(
  parameter int ROWS            = 4,
  parameter int COLS            = 4,
  parameter int SETTLE_CYCLES   = 4,
  parameter int DEBOUNCE_CYCLES = 8,
  parameter int HIST_DEPTH      = 2,
  parameter int ACTIVE_LOW      = 1,
  localparam int KEY_W          = $clog2(ROWS * COLS)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [ROWS-1:0]             row_in,
  output logic [COLS-1:0]             col,
  output logic [KEY_W-1:0]            key_code,
  output logic                        key_valid,
  output logic [HIST_DEPTH*KEY_W-1:0] hist,
  output logic                        multi_err
);

  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int CNT_W = $clog2(max_f(SETTLE_CYCLES, DEBOUNCE_CYCLES) + 1);

  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DEB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [COLS-1:0]  COL_ONE     = COLS'(1);
  localparam logic [COLS-1:0]  COL_RESET   = (ACTIVE_LOW != 0) ? ~COL_ONE : COL_ONE;

  logic [ROWS-1:0] row_sync;
  logic [ROWS-1:0] rows_act;

  synchronizer #(
    .WIDTH    (ROWS),
    .RESET_VAL(ACTIVE_LOW != 0)
  ) u_row_sync (
    .clk  (clk),
    .reset(reset),
    .d_i  (row_in),
    .q_o  (row_sync)
  );

  assign rows_act = (ACTIVE_LOW != 0) ? ~row_sync : row_sync;

  kp_state_e                   state_q, state_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic [COL_W-1:0]            col_idx_q, col_idx_d;
  logic [ROW_W-1:0]            row_idx_q, row_idx_d;
  logic [COLS-1:0]             col_q, col_d;
  logic [KEY_W-1:0]            key_code_q, key_code_d;
  logic                        key_valid_q, key_valid_d;
  logic [HIST_DEPTH*KEY_W-1:0] hist_q, hist_d;
  logic                        multi_err_q, multi_err_d;

  logic [ROW_W-1:0]            hit_idx;
  logic                        none_act, one_act, latched_bit;
  logic [COL_W-1:0]            col_next;
  logic [KEY_W-1:0]            new_code;
  logic [HIST_DEPTH*KEY_W-1:0] hist_shift;

  always_comb begin
    hit_idx = '0;
    for (int r = 0; r < ROWS; r++) begin
      if (rows_act[r]) hit_idx = ROW_W'(r);
    end
  end

  assign none_act    = (rows_act == '0);
  assign one_act     = $onehot(rows_act);
  assign latched_bit = rows_act[row_idx_q];
  assign col_next    = (col_idx_q == COL_W'(COLS - 1)) ? '0 : col_idx_q + 1'b1;
  assign new_code    = KEY_W'(key_code_f(32'(row_idx_q), 32'(col_idx_q), COLS));

  // History shifts toward the MSBs; the oldest slice falls off the top.
  for (genvar gi = 0; gi < HIST_DEPTH; gi++) begin : g_hist
    if (gi == 0) begin : g_newest
      assign hist_shift[KEY_W-1:0] = new_code;
    end else begin : g_older
      assign hist_shift[gi*KEY_W +: KEY_W] = hist_q[(gi-1)*KEY_W +: KEY_W];
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    col_idx_d   = col_idx_q;
    row_idx_d   = row_idx_q;
    key_code_d  = key_code_q;
    hist_d      = hist_q;
    key_valid_d = 1'b0;
    multi_err_d = 1'b0;

    case (state_q)
      SCAN: begin
        if (cnt_q == SETTLE_LAST) begin
          cnt_d = '0;
          if (one_act) begin
            row_idx_d = hit_idx;
            state_d   = DEBOUNCE;
          end else begin
            col_idx_d   = col_next;
            multi_err_d = !none_act;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DEBOUNCE: begin
        if (!latched_bit) begin
          state_d   = SCAN;
          cnt_d     = '0;
          col_idx_d = col_next;
        end else if (cnt_q == DEB_LAST) begin
          state_d     = HELD;
          cnt_d       = '0;
          key_code_d  = new_code;
          key_valid_d = 1'b1;
          hist_d      = hist_shift;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HELD: begin
        if (!latched_bit) begin
          state_d = RELEASE;
          cnt_d   = '0;
        end
      end
      RELEASE: begin
        if (latched_bit) begin
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt_q == DEB_LAST) begin
          state_d   = SCAN;
          cnt_d     = '0;
          col_idx_d = col_next;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = SCAN;
        cnt_d   = '0;
      end
    endcase

    col_d = (ACTIVE_LOW != 0) ? ~(COL_ONE << col_idx_d) : (COL_ONE << col_idx_d);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= SCAN;
      cnt_q       <= '0;
      col_idx_q   <= '0;
      row_idx_q   <= '0;
      col_q       <= COL_RESET;
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
      hist_q      <= '0;
      multi_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      col_idx_q   <= col_idx_d;
      row_idx_q   <= row_idx_d;
      col_q       <= col_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      hist_q      <= hist_d;
      multi_err_q <= multi_err_d;
    end
  end

  assign col       = col_q;
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign hist      = hist_q;
  assign multi_err = multi_err_q;

endmodule

// File: tb/tb_keypad_matrix_capture.sv
// Scoreboarded bench: scenarios push expected key events, a monitor pops and
// compares them whenever key_valid strobes.
module tb_keypad_matrix_capture;

  localparam int ROWS = 4;
  localparam int COLS = 4;
  localparam int HD   = 3;
  localparam int KW   = 4;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [ROWS-1:0]      row_in;
  logic [COLS-1:0]      col;
  logic [KW-1:0]        key_code;
  logic                 key_valid;
  logic [HD*KW-1:0]     hist;
  logic                 multi_err;

  logic [ROWS-1:0][COLS-1:0] pressed;

  typedef struct packed {
    logic [KW-1:0]    code;
    logic [HD*KW-1:0] hist;
  } exp_t;

  exp_t             exp_q[$];
  logic [HD*KW-1:0] model_hist;
  int               errors = 0;
  int               checks = 0;
  int               multi_cnt = 0;

  keypad_matrix_capture #(
    .ROWS(ROWS), .COLS(COLS), .SETTLE_CYCLES(4), .DEBOUNCE_CYCLES(8),
    .HIST_DEPTH(HD), .ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .reset(reset), .row_in(row_in), .col(col),
    .key_code(key_code), .key_valid(key_valid), .hist(hist), .multi_err(multi_err)
  );

  always #5 clk = ~clk;

  // Passive switch matrix: a pressed key pulls its row low while its column is driven low.
  always_comb begin
    row_in = '1;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (pressed[r][c] && col[c] == 1'b0) row_in[r] = 1'b0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end else begin
      $display("ok   %s: %0h at %0t", name, act, $time);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_key(input int code);
    exp_t e;
    model_hist = {model_hist[(HD-1)*KW-1:0], KW'(code)};
    e.code = KW'(code);
    e.hist = model_hist;
    exp_q.push_back(e);
  endtask

  task automatic wait_col_start(input logic [COLS-1:0] target);
    logic [COLS-1:0] prev;
    logic found;
    found = 1'b0;
    prev  = col;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (col == target && prev != target) found = 1'b1;
      prev = col;
    end
    check("col_wait", 32'(found), 1);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 80 && exp_q.size() != 0; i++) @(negedge clk);
    check(name, exp_q.size(), 0);
  endtask

  task automatic press_release(input int code, input int hold, input int gap);
    pressed[code / COLS][code % COLS] = 1'b1;
    expect_key(code);
    cycles(hold);
    pressed = '0;
    cycles(gap);
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      if (key_valid || multi_err) check("valid_err_exclusive", 32'(key_valid & multi_err), 0);
      if (multi_err) multi_cnt++;
      if (key_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_key_valid", exp_q.size(), 1);
        end else begin
          e = exp_q.pop_front();
          check("event_code", 32'(key_code), 32'(e.code));
          check("event_hist", 32'(hist), 32'(e.hist));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    int col_seq [4];
    col_seq = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    pressed    = '0;
    model_hist = '0;
    reset      = 1'b1;
    cycles(3);

    // 1: reset state and free-running scan
    check("reset_col", 32'(col), 32'(4'b1110));
    check("reset_key_code", 32'(key_code), 0);
    check("reset_hist", 32'(hist), 0);
    check("reset_key_valid", 32'(key_valid), 0);
    check("reset_multi_err", 32'(multi_err), 0);
    reset = 1'b0;
    for (int i = 0; i <= 16; i++) begin
      check("scan_col", 32'(col), 32'(col_seq[(i / 4) % 4]));
      @(negedge clk);
    end

    // 2: clean press row 2 / col 1
    press_release(9, 50, 30);
    drain("clean_press_drained");
    check("clean_key_code", 32'(key_code), 9);
    check("clean_hist0", 32'(hist[KW-1:0]), 9);

    // 3: bounce aligned to the col-1 dwell so the first burst reaches DEBOUNCE
    wait_col_start(4'b1101);
    pressed[2][1] = 1'b1;
    expect_key(9);
    cycles(5);
    pressed[2][1] = 1'b0;
    cycles(1);
    pressed[2][1] = 1'b1;
    cycles(50);
    pressed = '0;
    cycles(30);
    drain("bounce_drained");

    // 4: two rows on col 2 across exactly four scan rounds
    wait_col_start(4'b1110);
    multi_cnt = 0;
    pressed[0][2] = 1'b1;
    pressed[3][2] = 1'b1;
    cycles(64);
    pressed = '0;
    check("multi_err_count", multi_cnt, 4);
    check("multi_no_event", exp_q.size(), 0);

    // 5: key sequence fills the history
    press_release(1, 40, 30);
    press_release(5, 40, 30);
    press_release(10, 40, 30);
    press_release(15, 40, 30);
    drain("sequence_drained");
    check("seq_key_code", 32'(key_code), 15);
    check("seq_hist", 32'(hist), 32'({4'd5, 4'd10, 4'd15}));

    // 6a: reset during DEBOUNCE
    wait_col_start(4'b1101);
    pressed[2][1] = 1'b1;
    cycles(6);
    reset = 1'b1;
    #1;
    check("rst_deb_col", 32'(col), 32'(4'b1110));
    check("rst_deb_hist", 32'(hist), 0);
    check("rst_deb_key_code", 32'(key_code), 0);
    check("rst_deb_key_valid", 32'(key_valid), 0);
    model_hist = '0;
    pressed = '0;
    cycles(2);
    reset = 1'b0;
    cycles(1);
    check("rst_deb_restart_col", 32'(col), 32'(4'b1110));
    cycles(30);

    // 6b: reset during HELD
    pressed[2][1] = 1'b1;
    expect_key(9);
    cycles(40);
    drain("held_event_drained");
    reset = 1'b1;
    #1;
    check("rst_held_col", 32'(col), 32'(4'b1110));
    check("rst_held_hist", 32'(hist), 0);
    check("rst_held_key_code", 32'(key_code), 0);
    model_hist = '0;
    pressed = '0;
    cycles(2);
    reset = 1'b0;
    cycles(40);
    check("rst_held_no_event", exp_q.size(), 0);
    check("rst_held_hist_after", 32'(hist), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
